// File: rtl/uart_word_tx.sv
// Word-wide 8N1 UART transmitter: sends NBYTES bytes of an accepted 32-bit word, LSB byte first.
// Every output is a flop so the serial line and handshake carry no combinational path from the inputs.
module uart_word_tx #(
    parameter int CLK_PER_HALF_BIT = 5208,
    parameter int NBYTES           = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    output logic        txd,
    output logic        busy,
    output logic        byte_done
);

    localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
    localparam int TW      = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
    localparam logic [TW-1:0] BIT_LOAD  = TW'(BIT_CYC - 1);
    localparam logic [1:0]    LAST_BYTE = 2'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [31:0]   shreg_q, shreg_d;
    logic          txd_q, txd_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          byte_done_q, byte_done_d;
    logic          bit_end;

    assign bit_end = (timer_q == '0);

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        timer_d    = timer_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shreg_d    = shreg_q;

        case (state_q)
            IDLE: begin
                if (word_valid && ready_q) begin
                    state_d    = START;
                    timer_d    = BIT_LOAD;
                    shreg_d    = word_in;
                    byte_idx_d = '0;
                    bit_idx_d  = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    timer_d   = BIT_LOAD;
                    bit_idx_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_d = BIT_LOAD;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_idx_q < LAST_BYTE) begin
                        // Next byte starts immediately: no idle gap between frames of one word.
                        state_d    = START;
                        timer_d    = BIT_LOAD;
                        byte_idx_d = byte_idx_q + 2'd1;
                        shreg_d    = {8'h00, shreg_q[31:8]};
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are derived from the next state so the registered copies line up with it.
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shreg_d[bit_idx_d];
            default: txd_d = 1'b1;
        endcase
        ready_d     = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        byte_done_d = (state_d == STOP) && (timer_d == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            byte_idx_q  <= '0;
            txd_q       <= 1'b1;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            byte_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            byte_idx_q  <= byte_idx_d;
            txd_q       <= txd_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            byte_done_q <= byte_done_d;
        end
    end

    // NOTE: the shift register is pure datapath, always loaded on accept before use, so it needs no reset.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign txd        = txd_q;
    assign word_ready = ready_q;
    assign busy       = busy_q;
    assign byte_done  = byte_done_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: table-driven and random words against a frame-level model,
// plus a line sampler that decodes bytes, and hand-written hold, reset and line-rate sequences.
module tb_uart_word_tx;

    localparam int CPH       = 2;
    localparam int BC        = 2 * CPH;
    localparam int NB        = 4;
    localparam int BYTE_CYC  = 10 * BC;
    localparam int FRAME_CYC = NB * BYTE_CYC;
    localparam int FAST_BC   = 10416;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] word_in;
    logic        word_valid;
    logic        word_ready, txd, busy, byte_done;

    logic        rst_f;
    logic [31:0] word_f;
    logic        valid_f;
    logic        ready_f, txd_f, busy_f, byte_done_f;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] rx_q[$];
    bit         smp_clr = 1'b1;

    always #5 clk = ~clk;

    uart_word_tx #(.CLK_PER_HALF_BIT(CPH), .NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .word_in   (word_in),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .txd       (txd),
        .busy      (busy),
        .byte_done (byte_done)
    );

    uart_word_tx dut_fast (
        .clk       (clk),
        .rst       (rst_f),
        .word_in   (word_f),
        .word_valid(valid_f),
        .word_ready(ready_f),
        .txd       (txd_f),
        .busy      (busy_f),
        .byte_done (byte_done_f)
    );

    typedef struct packed {
        logic [31:0]     word;
        logic [3:0][7:0] b;    // b[0] is the first byte expected on the line
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected line level c cycles after the accept edge, from the frame layout {start, d0..d7, stop}.
    function automatic logic exp_txd(input logic [31:0] w, input int c);
        int k   = c / BYTE_CYC;
        int pos = (c % BYTE_CYC) / BC;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return w[8*k + pos - 1];
    endfunction

    // Line sampler: finds a start bit, samples mid-bit, pushes each decoded byte.
    initial begin : sampler
        int cnt;
        int j;
        bit active;
        logic [7:0] sh;
        cnt = 0; active = 1'b0; sh = '0;
        forever begin
            @(negedge clk);
            if (smp_clr) begin
                active = 1'b0;
            end else if (!active) begin
                if (txd === 1'b0) begin
                    active = 1'b1;
                    cnt    = 0;
                end
            end else begin
                cnt++;
                if (cnt % BC == BC / 2) begin
                    j = cnt / BC;
                    if (j >= 1 && j <= 8) begin
                        sh[j-1] = txd;
                    end else if (j == 9) begin
                        rx_q.push_back(sh);
                        active = 1'b0;
                    end
                end
            end
        end
    end

    task automatic check_frames(input logic [31:0] w);
        for (int c = 0; c < FRAME_CYC; c++) begin
            @(negedge clk);
            check($sformatf("txd@%0d", c), 32'(txd), 32'(exp_txd(w, c)));
            check($sformatf("ready@%0d", c), 32'(word_ready), 32'd0);
            check($sformatf("busy@%0d", c), 32'(busy), 32'd1);
            check($sformatf("byte_done@%0d", c), 32'(byte_done),
                  32'((c % BYTE_CYC) == BYTE_CYC - 1));
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, 32'(word_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_txd"}, 32'(txd), 32'd1);
        check({tag, "_byte_done"}, 32'(byte_done), 32'd0);
    endtask

    task automatic check_rx(input string tag, input logic [63:0] exp, input int n);
        logic [31:0] act;
        check({tag, "_rx_count"}, 32'(rx_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            act = (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hDEAD_0000;
            check($sformatf("%s_rx_byte%0d", tag, i), act, 32'(exp[8*i +: 8]));
        end
        rx_q.delete();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (word_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // Called at a negedge; returns at the negedge where word_ready should be back.
    task automatic send_word(input logic [31:0] w, input string tag);
        wait_ready();
        word_in    = w;
        word_valid = 1'b1;
        @(posedge clk);
        #1;
        word_valid = 1'b0;
        word_in    = $urandom;
        check_frames(w);
        @(negedge clk);
        check_idle({tag, "_end"});
    endtask

    initial begin
        vec_t tbl[5];
        logic [31:0] w;
        int n;

        tbl[0] = '{32'h000000A5, {8'h00, 8'h00, 8'h00, 8'hA5}};
        tbl[1] = '{32'h12345678, {8'h12, 8'h34, 8'h56, 8'h78}};
        tbl[2] = '{32'h80000001, {8'h80, 8'h00, 8'h00, 8'h01}};
        tbl[3] = '{32'hFFFFFFFF, {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
        tbl[4] = '{32'h00000000, {8'h00, 8'h00, 8'h00, 8'h00}};

        rst = 1'b1; word_in = '0; word_valid = 1'b0;
        rst_f = 1'b1; word_f = '0; valid_f = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        smp_clr = 1'b0;

        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            check_idle($sformatf("idle%0d", c));
        end

        for (int i = 0; i < 5; i++) begin
            send_word(tbl[i].word, $sformatf("tbl%0d", i));
            check_rx($sformatf("tbl%0d", i), {32'h0, tbl[i].b}, NB);
        end

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            w = $urandom;
            send_word(w, $sformatf("rnd%0d", i));
            check_rx($sformatf("rnd%0d", i), {32'h0, w}, NB);
        end

        // Held valid: input changes are ignored mid-word, next word goes out after one idle cycle.
        word_in    = 32'hDEADBEEF;
        word_valid = 1'b1;
        @(posedge clk);
        #1 word_in = 32'h0;
        check_frames(32'hDEADBEEF);
        @(negedge clk);
        check_idle("hold_gap");
        check_frames(32'h0);
        @(negedge clk);
        word_valid = 1'b0;
        check_idle("hold_end");
        check_rx("hold", 64'h00000000_DEADBEEF, 8);

        // Reset one cycle mid-frame: line snaps high and no byte_done follows.
        word_in = 32'hFFFFFFFF;
        word_valid = 1'b1;
        @(posedge clk);
        #1 word_valid = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        smp_clr = 1'b1;
        @(negedge clk);
        check_idle("rst_mid");
        n = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (byte_done !== 1'b0 || txd !== 1'b1 || word_ready !== 1'b1) n++;
        end
        check("rst_mid_quiet", 32'(n), 32'd0);

        // Reset mid-DATA with word_valid present the cycle after release: accepted normally.
        rx_q.delete();
        word_in = 32'h3C3C3C3C;
        word_valid = 1'b1;
        @(posedge clk);
        #1 word_valid = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        word_in = 32'h0000C35A;
        word_valid = 1'b1;
        @(negedge clk);
        check_idle("rst_data");
        @(posedge clk);
        #1 word_valid = 1'b0;
        smp_clr = 1'b0;
        rx_q.delete();
        check_frames(32'h0000C35A);
        @(negedge clk);
        check_idle("rst_data_end");
        check_rx("rst_data", 64'h00000000_0000C35A, NB);

        // Line rate with default timing: start bit and first data bit widths.
        @(negedge clk);
        rst_f = 1'b0;
        @(negedge clk);
        check("fast_ready", 32'(ready_f), 32'd1);
        word_f  = 32'h00000001;
        valid_f = 1'b1;
        @(posedge clk);
        #1 valid_f = 1'b0;
        @(negedge clk);
        check("fast_busy", 32'(busy_f), 32'd1);
        check("fast_byte_done", 32'(byte_done_f), 32'd0);
        n = 0;
        while (txd_f === 1'b0 && n < 20000) begin
            n++;
            @(negedge clk);
        end
        check("fast_start_width", 32'(n), 32'(FAST_BC));
        n = 0;
        while (txd_f === 1'b1 && n < 20000) begin
            n++;
            @(negedge clk);
        end
        check("fast_bit0_width", 32'(n), 32'(FAST_BC));
        rst_f = 1'b1;
        @(posedge clk);
        #1 rst_f = 1'b0;
        @(negedge clk);
        check("fast_rst_txd", 32'(txd_f), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
- UART transmitter that serialises one 32-bit word as four 8N1 bytes on `txd`, least-significant byte first.
- It is the transmit-direction counterpart to the core's receive path. It reports `output_register` (or any 32-bit result) to the host over the same serial link and at the same baud configuration as the receiver.
- It has a valid/ready word input and a single serial output, and runs in one clock domain.

Parameters:
- CLK_PER_HALF_BIT, 5208, clocks per half bit period. One bit period is BIT_CYC = 2*CLK_PER_HALF_BIT clocks, which is 10416 clocks (9600 baud) at 100 MHz. Legal range is 1 to 2^20.
- NBYTES, 4, bytes sent per accepted word, LSB first. Legal range is 1 to 4; bytes above NBYTES-1 are ignored.

Ports:
- clk  input  1  system clock; every flop is on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- word_in  input  32  word to transmit; sampled only on the accept cycle.
- word_valid  input  1  producer has a word on word_in.
- word_ready  output  1  block can accept a word this cycle.
- txd  output  1  serial line; idles high.
- busy  output  1  a frame sequence is in progress.
- byte_done  output  1  one-cycle pulse in the last cycle of each byte's stop bit.

Behaviour:
- Reset (rst=1 at a rising edge):
  - Next-cycle values: txd=1, word_ready=1, busy=0, byte_done=0. All counters clear and the state is IDLE.
  - Reset takes priority over everything, including mid-frame; the line returns high with no partial stop bit.
- word_ready equals (state==IDLE) and is registered. busy is the complement of word_ready.
- Accept occurs on a cycle where word_valid && word_ready.
  - The block latches word_in into a shift register and clears byte_idx to 0.
  - In the following cycle: state=START, txd=0, word_ready=0.
  - word_in and word_valid are ignored until the block returns to IDLE.
- States and transitions:
  - IDLE: txd=1. Leaves only on accept, to START.
  - START: txd=0 for BIT_CYC cycles, then DATA with bit_idx=0.
  - DATA: txd = current byte bit[bit_idx]. Each bit is held BIT_CYC cycles. After bit 7 completes, go to STOP.
  - STOP: txd=1 for BIT_CYC cycles. byte_done pulses in its final cycle. Then:
    - if byte_idx < NBYTES-1: increment byte_idx, shift the word right 8, go to START with no idle gap;
    - otherwise go to IDLE.
- Bit timer:
  - A down-counter loads BIT_CYC-1 on every state or bit entry and advances at 0.
  - Every bit is exactly BIT_CYC cycles; there is no drift across bytes.
- Timing:
  - One byte frame is 10*BIT_CYC cycles.
  - From the accept edge to word_ready re-asserting is NBYTES*10*BIT_CYC cycles.
  - Back-to-back: if word_valid is held high, the next word is accepted on the first IDLE cycle. This gives exactly one IDLE cycle (txd=1) between words.
- Byte order:
  - byte k carries word_in[8k+7:8k], for k = 0..NBYTES-1.
  - Within a byte, bit 0 is sent first.
- txd, word_ready, busy and byte_done are all driven directly from flops, with no combinational path from inputs.
- Reset asserted for a single cycle mid-DATA: the next cycle is IDLE with txd=1. A word_valid present in the cycle after reset is released is accepted normally.

Test Plan (CLK_PER_HALF_BIT=2, so BIT_CYC=4; NBYTES=4):
- Reset then idle: hold rst 2 cycles, word_valid=0 for 100 cycles -> txd=1, word_ready=1, busy=0 throughout.
- Single word: word_in=0x000000A5 with a one-cycle valid pulse.
  - txd low the next cycle for 4 cycles.
  - Data bits 1,0,1,0,0,1,0,1, each 4 cycles, then stop high 4 cycles.
  - Bytes 0x00,0x00,0x00 follow.
  - word_ready returns exactly 160 cycles after accept; byte_done pulses 4 times at 40-cycle spacing.
- Byte order: word_in=0x12345678 -> a bench-side UART sampler decodes the sequence 0x78,0x56,0x34,0x12.
- Hold/ignore: accept 0xDEADBEEF, then change word_in to 0x0 and keep word_valid=1 throughout.
  - Decoded output is EF,BE,AD,DE.
  - The second word (0x0) is accepted in the first IDLE cycle; exactly one idle-high cycle separates the words.
- Reset mid-frame: accept 0xFFFFFFFF, assert rst for 1 cycle at cycle 50 -> txd=1 and word_ready=1 from cycle 51, and no further byte_done.
- Line-rate check (default CLK_PER_HALF_BIT=5208): send 0x00000001 -> start-bit width is exactly 10416 cycles, and the total word time is 416640 cycles.
